sm_run_ctrl: RTL and testbench
==============================

# sm_run_ctrl

Execution controller for the schoolMIPS core. It sits between a host/debug command source and `sm_top`, and drives `sm_top.clkEnable` so the CPU can be halted, free-run, single/multi-stepped, or stopped at a PC breakpoint. It observes the current PC through the `regAddr = 0` / `regData` debug port and counts executed CPU cycles.

## Interface
- `RESET_RUN`, default 0: if 1, the block leaves reset in RUN; if 0, it leaves reset in HALT.
- `clk` in 1: the single clock; same as `sm_top` `clkIn`, with the divider bypassed.
- `rst_n` in 1: synchronous, active-low reset.
- `cmdValid` in 1: command strobe.
- `cmdReady` out 1: the command is accepted on `cmdValid && cmdReady`.
- `cmdOp` in 3: opcode. HALT=0, RUN=1, STEP=2, BPSET=3, BPCLR=4. Codes 5–7 are accepted and have no effect.
- `cmdArg` in 16: step count for STEP; breakpoint word address for BPSET.
- `abort` in 1: level input. Forces HALT from any state and has priority over commands.
- `pc` in 32: the word PC, read from `regData` with `regAddr` tied to 0.
- `cpuEn` out 1: drives `sm_top.clkEnable`.
- `state` out 2: HALT=0, RUN=1, STEP=2, BREAK=3.
- `cycCnt` out 32: the number of cycles with `cpuEn=1`.

## Operation
- **Registered state:** `state`, `stepCnt[15:0]`, `bpAddr[15:0]`, `bpEn`, `skip`, `cycCnt`.
- **Reset values:** `state` = HALT, or RUN if `RESET_RUN=1`. `stepCnt`, `bpAddr`, `bpEn`, `skip` and `cycCnt` reset to 0.
- **Outputs during reset:** while `rst_n=0`, `cpuEn=0`, `cmdReady=0` and `state` = HALT.
- **Breakpoint hit:** `bpHit = bpEn && (pc[15:0] == bpAddr) && !skip`.
- **CPU enable:** `cpuEn = (state==RUN || state==STEP) && !bpHit && !abort`. It is combinational from registered state and the `pc`/`abort` inputs, so the CPU never executes the instruction at a breakpoint.
- **Command ready:** `cmdReady = rst_n && (state != STEP) && !abort`. STEP can only be interrupted by `abort` or a breakpoint.
- **HALT command:** next state is HALT.
- **RUN command:** next state is RUN and `skip` is set to 1.
- **STEP command:** `stepCnt` loads `cmdArg`, with `cmdArg=0` loaded as 1. Next state is STEP and `skip` is set to 1.
- **BPSET command:** `bpAddr` loads `cmdArg` and `bpEn` is set to 1. State is unchanged.
- **BPCLR command:** `bpEn` is cleared to 0. State is unchanged.
- **Clearing `skip`:** `skip` clears on the first cycle with `cpuEn=1` after it was set. This lets execution resume from a breakpoint PC.
- **RUN state:** if `bpHit`, go to BREAK. Otherwise stay in RUN.
- **STEP state:**
  - If `bpHit`, go to BREAK; `stepCnt` holds.
  - Otherwise, if `cpuEn`, `stepCnt` decrements. When `stepCnt==1`, go to HALT.
- **HALT and BREAK:** they differ only in encoding. Both hold until a command or `abort` arrives.
- **Abort:** `abort=1` gives next state HALT; any simultaneous command handshake is suppressed because `cmdReady=0`.
- **Cycle counter:** `cycCnt` increments whenever `cpuEn=1` and wraps modulo 2^32. Only reset clears it.
- **Breakpoint compare width:** only `pc[15:0]` is compared; `pc[31:16]` is ignored.

## Timing
- **Command to effect:** a command accepted in cycle N sets the new `state` at edge N+1. `cpuEn` can first be 1 in cycle N+1.
- **STEP length:** `STEP k` gives exactly k cycles with `cpuEn=1`, unless a breakpoint or abort intervenes. `state` reads HALT in the cycle after the last enabled cycle.
- **Breakpoint response:** same cycle. `cpuEn` drops combinationally in the cycle where `pc` matches, and `state` = BREAK from the next edge.
- **BPSET during RUN:** the new `bpAddr` is compared from the following cycle.
- **Reset mid-STEP or mid-RUN:** the same-edge synchronous reset gives the reset values above. The step count in progress is discarded.

## Structure
- **Shared header `sm_dbg.vh`:** holds the opcode defines (`DBG_OP_*`) and the state encodings (`DBG_ST_*`). It is shared with the testbench disassembler/printer.
- **Sub-module:** one natural sub-module, `sm_dbg_stepcnt`. It holds the 16-bit loadable down-counter with load-0-as-1 and a `last` flag. Everything else stays flat in `sm_run_ctrl`.

## Test plan
- **Reset default:** with `RESET_RUN=0`, release reset and hold for 10 cycles → `cpuEn=0` throughout, `state=0`, `cycCnt=0`.
- **Step count:** RUN from HALT, then HALT after 5 cycles → `cycCnt=5`. Then `STEP 3` → exactly 3 `cpuEn` pulses, `state` back to 0, `cycCnt=8`. Then `STEP 0` → exactly 1 pulse.
- **Breakpoint and resume:** `BPSET 4`, then RUN on a program with a straight line from PC 0 → `cpuEn` low in the cycle where `pc==4`, `state=3`, `pc` stays 4. A second RUN executes the PC-4 instruction (skip) and continues.
- **Abort during STEP:** issue `STEP 1000` and assert `abort` after 20 cycles → `cpuEn=0` in that same cycle, `state=0` next cycle, `cmdReady=0` while `abort` is high.
- **BPCLR:** `BPSET 4`, then `BPCLR`, then RUN → PC passes 4 without stopping. Command op 6 → accepted, with no change to state or breakpoint.
- **Wrap and reset:** force `cycCnt` to 32'hFFFF_FFFE and run 3 cycles → `cycCnt=1`. Assert `rst_n=0` mid-STEP → all reset values at the next edge.

Source files
------------

// File: rtl/sm_run_ctrl_pkg.sv
// sm_run_ctrl_pkg: debug opcodes, run-state encodings and step-load helper
package sm_run_ctrl_pkg;

    localparam logic [2:0] DBG_OP_HALT  = 3'd0;
    localparam logic [2:0] DBG_OP_RUN   = 3'd1;
    localparam logic [2:0] DBG_OP_STEP  = 3'd2;
    localparam logic [2:0] DBG_OP_BPSET = 3'd3;
    localparam logic [2:0] DBG_OP_BPCLR = 3'd4;

    typedef enum logic [1:0] {
        DBG_ST_HALT  = 2'd0,
        DBG_ST_RUN   = 2'd1,
        DBG_ST_STEP  = 2'd2,
        DBG_ST_BREAK = 2'd3
    } dbg_state_e;

    // A zero step request still executes one instruction
    function automatic logic [15:0] step_load(input logic [15:0] arg);
        return (arg == 16'd0) ? 16'd1 : arg;
    endfunction

endpackage

// File: rtl/sm_dbg_stepcnt.sv
// sm_dbg_stepcnt: loadable 16-bit step down-counter with last-step flag
module sm_dbg_stepcnt
    import sm_run_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        dec,
    output logic        last
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Load has priority; a load and a decrement never coincide in the controller
    always_comb begin
        cnt_d = load ? step_load(load_val) : (dec ? cnt_q - 16'd1 : cnt_q);
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= 16'd0;
        else        cnt_q <= cnt_d;
    end

    assign last = (cnt_q == 16'd1);

endmodule

// File: rtl/sm_run_ctrl.sv
// sm_run_ctrl: halt/run/step/breakpoint execution controller for schoolMIPS
module sm_run_ctrl
    import sm_run_ctrl_pkg::*;
#(
    parameter bit RESET_RUN = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmdValid,
    output logic        cmdReady,
    input  logic [2:0]  cmdOp,
    input  logic [15:0] cmdArg,
    input  logic        abort,
    input  logic [31:0] pc,
    output logic        cpuEn,
    output logic [1:0]  state,
    output logic [31:0] cycCnt
);

    localparam dbg_state_e RST_STATE = RESET_RUN ? DBG_ST_RUN : DBG_ST_HALT;

    dbg_state_e  state_q, state_d;
    logic [15:0] bp_addr_q, bp_addr_d;
    logic        bp_en_q, bp_en_d;
    logic        skip_q, skip_d;
    logic [31:0] cyc_cnt_q, cyc_cnt_d;
    logic        bp_hit, active, accept, step_last;
    logic        unused_pc_hi;

    assign unused_pc_hi = ^pc[31:16];

    // skip masks the breakpoint at the PC execution resumes from
    assign bp_hit   = bp_en_q && (pc[15:0] == bp_addr_q) && !skip_q;
    assign active   = (state_q == DBG_ST_RUN) || (state_q == DBG_ST_STEP);
    assign cpuEn    = rst_n && active && !bp_hit && !abort;
    assign cmdReady = rst_n && (state_q != DBG_ST_STEP) && !abort;
    assign accept   = cmdValid && cmdReady;
    assign state    = rst_n ? state_q : DBG_ST_HALT;
    assign cycCnt   = cyc_cnt_q;

    sm_dbg_stepcnt u_stepcnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept && (cmdOp == DBG_OP_STEP)),
        .load_val (cmdArg),
        .dec      ((state_q == DBG_ST_STEP) && cpuEn),
        .last     (step_last)
    );

    // Next state: execution events first, then commands, abort overrides all
    always_comb begin
        state_d   = state_q;
        bp_addr_d = bp_addr_q;
        bp_en_d   = bp_en_q;
        skip_d    = cpuEn ? 1'b0 : skip_q;
        cyc_cnt_d = cyc_cnt_q + {31'd0, cpuEn};
        if (active && bp_hit) state_d = DBG_ST_BREAK;
        else if ((state_q == DBG_ST_STEP) && cpuEn && step_last) state_d = DBG_ST_HALT;
        if (accept) begin
            case (cmdOp)
                DBG_OP_HALT: state_d = DBG_ST_HALT;
                DBG_OP_RUN: begin
                    state_d = DBG_ST_RUN;
                    skip_d  = 1'b1;
                end
                DBG_OP_STEP: begin
                    state_d = DBG_ST_STEP;
                    skip_d  = 1'b1;
                end
                DBG_OP_BPSET: begin
                    bp_addr_d = cmdArg;
                    bp_en_d   = 1'b1;
                end
                DBG_OP_BPCLR: bp_en_d = 1'b0;
                default: ;
            endcase
        end
        if (abort) state_d = DBG_ST_HALT;
    end

    // Controller registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RST_STATE;
            bp_addr_q <= 16'd0;
            bp_en_q   <= 1'b0;
            skip_q    <= 1'b0;
            cyc_cnt_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            bp_addr_q <= bp_addr_d;
            bp_en_q   <= bp_en_d;
            skip_q    <= skip_d;
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

endmodule

// File: tb/tb_sm_run_ctrl.sv
// tb_sm_run_ctrl: directed and random checks of sm_run_ctrl against a behavioural model
module tb_sm_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmdValid = 1'b0;
    logic [2:0]  cmdOp = 3'd0;
    logic [15:0] cmdArg = 16'd0;
    logic        abort = 1'b0;
    logic [31:0] pc;
    logic        cmdReady, cpuEn;
    logic [1:0]  state;
    logic [31:0] cycCnt;

    logic [15:0] pc_lo = 16'd0;
    logic [15:0] pc_hi = 16'd0;
    logic        pc_set_en = 1'b0;
    logic [15:0] pc_set_val = 16'd0;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    int          m_st = 0;
    int          m_left = 0;
    logic [15:0] m_bp = 16'd0;
    bit          m_bpen = 1'b0;
    bit          m_skip = 1'b0;
    logic [31:0] m_cyc = 32'd0;
    bit          seen_rst = 1'b0;
    bit          wrap_req = 1'b0;
    bit          forcing = 1'b0;

    assign pc = {pc_hi, pc_lo};

    sm_run_ctrl #(.RESET_RUN(1'b0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmdValid (cmdValid),
        .cmdReady (cmdReady),
        .cmdOp    (cmdOp),
        .cmdArg   (cmdArg),
        .abort    (abort),
        .pc       (pc),
        .cpuEn    (cpuEn),
        .state    (state),
        .cycCnt   (cycCnt)
    );

    always #5 clk = ~clk;

    // Straight-line program: PC advances on every enabled cycle unless reloaded
    always @(posedge clk) pc_lo <= pc_set_en ? pc_set_val : pc_lo + {15'd0, cpuEn};

    function automatic bit m_hit();
        return m_bpen && (pc[15:0] == m_bp) && !m_skip;
    endfunction

    function automatic bit m_en();
        return rst_n && (m_st == 1 || m_st == 2) && !m_hit() && !abort;
    endfunction

    function automatic bit m_rdy();
        return rst_n && (m_st != 2) && !abort;
    endfunction

    function automatic int m_state();
        return rst_n ? m_st : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare();
        chk("cpuEn", {31'd0, cpuEn}, {31'd0, m_en()});
        chk("cmdReady", {31'd0, cmdReady}, {31'd0, m_rdy()});
        chk("state", {30'd0, state}, m_state());
        if (seen_rst && !forcing) chk("cycCnt", cycCnt, m_cyc);
        if (cpuEn) pulses++;
    endtask

    task automatic model_step();
        bit en, rdy, hit;
        hit = m_hit();
        en  = m_en();
        rdy = m_rdy();
        if (!rst_n) begin
            m_st = 0; m_left = 0; m_bp = 16'd0; m_bpen = 0; m_skip = 0; m_cyc = 32'd0;
            seen_rst = 1'b1;
        end else begin
            if (en) begin
                m_cyc = m_cyc + 32'd1;
                m_skip = 0;
                if (m_st == 2) begin
                    m_left--;
                    if (m_left == 0) m_st = 0;
                end
            end
            if (hit && (m_st == 1 || m_st == 2)) m_st = 3;
            if (cmdValid && rdy) begin
                if (cmdOp == 3'd0) m_st = 0;
                if (cmdOp == 3'd1) begin m_st = 1; m_skip = 1; end
                if (cmdOp == 3'd2) begin m_st = 2; m_skip = 1; m_left = (cmdArg == 16'd0) ? 1 : int'(cmdArg); end
                if (cmdOp == 3'd3) begin m_bp = cmdArg; m_bpen = 1; end
                if (cmdOp == 3'd4) m_bpen = 0;
            end
            if (abort) m_st = 0;
            if (wrap_req) m_cyc = 32'hFFFF_FFFE;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [2:0] op, input logic [15:0] arg);
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdArg   = arg;
        tick();
        cmdValid = 1'b0;
    endtask

    task automatic set_pc(input logic [15:0] v);
        pc_set_en  = 1'b1;
        pc_set_val = v;
        tick();
        pc_set_en  = 1'b0;
    endtask

    task automatic wait_break();
        int n = 0;
        while (state != 2'd3 && n < 30) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int p0;
        logic [31:0] c0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_cpuEn", {31'd0, cpuEn}, 32'd0);
        chk("rst_cycCnt", cycCnt, 32'd0);

        cmd(3'd1, 16'd0);
        repeat (4) tick();
        cmd(3'd0, 16'd0);
        tick();
        chk("run5_cycCnt", cycCnt, 32'd5);

        p0 = pulses;
        cmd(3'd2, 16'd3);
        repeat (6) tick();
        chk("step3_pulses", pulses - p0, 32'd3);
        chk("step3_state", {30'd0, state}, 32'd0);
        chk("step3_cycCnt", cycCnt, 32'd8);
        p0 = pulses;
        cmd(3'd2, 16'd0);
        repeat (4) tick();
        chk("step0_pulses", pulses - p0, 32'd1);

        pc_hi = 16'hABCD;
        set_pc(16'd0);
        cmd(3'd3, 16'd4);
        c0 = cycCnt;
        cmd(3'd1, 16'd0);
        wait_break();
        chk("bp_state", {30'd0, state}, 32'd3);
        chk("bp_pc", {16'd0, pc_lo}, 32'd4);
        chk("bp_cpuEn", {31'd0, cpuEn}, 32'd0);
        chk("bp_cycles", cycCnt - c0, 32'd4);
        repeat (2) tick();
        chk("bp_pc_hold", {16'd0, pc_lo}, 32'd4);
        cmd(3'd1, 16'd0);
        repeat (3) tick();
        chk("resume_pc", {16'd0, pc_lo}, 32'd7);
        chk("resume_state", {30'd0, state}, 32'd1);
        cmd(3'd0, 16'd0);

        cmd(3'd2, 16'd1000);
        repeat (20) tick();
        chk("abort_pre_en", {31'd0, cpuEn}, 32'd1);
        abort = 1'b1;
        cmdValid = 1'b1;
        cmdOp = 3'd1;
        #1;
        chk("abort_cpuEn", {31'd0, cpuEn}, 32'd0);
        chk("abort_ready", {31'd0, cmdReady}, 32'd0);
        tick();
        chk("abort_state", {30'd0, state}, 32'd0);
        abort = 1'b0;
        cmdValid = 1'b0;
        tick();
        chk("abort_no_cmd", {30'd0, state}, 32'd0);

        set_pc(16'd0);
        cmd(3'd3, 16'd4);
        cmd(3'd4, 16'd0);
        cmd(3'd1, 16'd0);
        repeat (8) tick();
        chk("bpclr_pc", {16'd0, pc_lo}, 32'd8);
        chk("bpclr_state", {30'd0, state}, 32'd1);
        cmd(3'd0, 16'd0);

        set_pc(16'd0);
        cmd(3'd3, 16'd4);
        chk("op6_ready", {31'd0, cmdReady}, 32'd1);
        cmd(3'd6, 16'd9);
        chk("op6_state", {30'd0, state}, 32'd0);
        cmd(3'd1, 16'd0);
        wait_break();
        chk("op6_bp_state", {30'd0, state}, 32'd3);
        chk("op6_bp_pc", {16'd0, pc_lo}, 32'd4);
        cmd(3'd4, 16'd0);
        cmd(3'd0, 16'd0);

        force dut.cyc_cnt_q = 32'hFFFF_FFFE;
        forcing = 1'b1;
        wrap_req = 1'b1;
        tick();
        release dut.cyc_cnt_q;
        forcing = 1'b0;
        wrap_req = 1'b0;
        cmd(3'd1, 16'd0);
        repeat (2) tick();
        cmd(3'd0, 16'd0);
        chk("wrap_cycCnt", cycCnt, 32'd1);

        cmd(3'd3, 16'd7);
        cmd(3'd2, 16'd50);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("rstmid_cpuEn", {31'd0, cpuEn}, 32'd0);
        chk("rstmid_ready", {31'd0, cmdReady}, 32'd0);
        chk("rstmid_state", {30'd0, state}, 32'd0);
        tick();
        chk("rstmid_cycCnt", cycCnt, 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("rstmid_after_state", {30'd0, state}, 32'd0);
        chk("rstmid_after_cpuEn", {31'd0, cpuEn}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            rst_n      = ($urandom_range(0, 399) != 0);
            abort      = ($urandom_range(0, 29) == 0);
            pc_set_en  = ($urandom_range(0, 19) == 0);
            pc_set_val = 16'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) pc_hi = 16'($urandom);
            cmdValid   = ($urandom_range(0, 2) == 0);
            cmdOp      = 3'($urandom_range(0, 7));
            cmdArg     = (cmdOp == 3'd2) ? 16'($urandom_range(0, 6)) :
                         (cmdOp == 3'd3) ? pc_lo + 16'($urandom_range(0, 5)) : 16'($urandom);
            tick();
        end
        rst_n = 1'b1;
        abort = 1'b0;
        cmdValid = 1'b0;
        pc_set_en = 1'b0;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
